// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_stage_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    // Fetch stage side: issues requests, receives responses.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: observes requests, returns responses.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus, feeds the
// IF/ID register, honours freeze and branch redirects, 1-entry skid on freeze.
module if_fetch_stage #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          DATA_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    if_fetch_stage_if.master  imem,
    output logic              valid_out,
    output logic [DATA_W-1:0] instruction_out,
    output logic [ADDR_W-1:0] pc_out
);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic              req_q;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] br_target;
    logic              ack_v;

    // Next sequential PC, word-aligned redirect target, ack qualified by a live request.
    assign pc_seq    = pc + PC_STEP;
    assign br_target = {br_addr[ADDR_W-1:2], 2'b00};
    assign ack_v     = imem.imem_ack && req_q;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    // Fetch FSM: PC, request bus, skid buffer and IF/ID output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= FETCH;
            pc              <= RESET_PC;
            addr_q          <= RESET_PC;
            req_q           <= 1'b0;
            valid_out       <= 1'b0;
            instruction_out <= '0;
            pc_out          <= '0;
            skid_instr      <= '0;
            skid_pc         <= '0;
        end else if (br_taken) begin
            valid_out <= 1'b0;
            pc        <= br_target;
            req_q     <= 1'b1;
            // A request still in flight must be drained before refetching.
            if (state != HOLD && req_q && !ack_v) begin
                state <= DRAIN;
            end else begin
                state  <= FETCH;
                addr_q <= br_target;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (ack_v) begin
                        pc     <= pc_seq;
                        addr_q <= pc_seq;
                        if (!valid_out || !freeze) begin
                            valid_out       <= 1'b1;
                            instruction_out <= imem.imem_rdata;
                            pc_out          <= pc_seq;
                        end else begin
                            skid_instr <= imem.imem_rdata;
                            skid_pc    <= pc_seq;
                            req_q      <= 1'b0;
                            state      <= HOLD;
                        end
                    end else begin
                        req_q <= 1'b1;
                        if (!freeze) begin
                            valid_out <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        valid_out       <= 1'b1;
                        instruction_out <= skid_instr;
                        pc_out          <= skid_pc;
                        req_q           <= 1'b1;
                        state           <= FETCH;
                    end
                end
                DRAIN: begin
                    if (!freeze) begin
                        valid_out <= 1'b0;
                    end
                    if (ack_v) begin
                        addr_q <= pc;
                        state  <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized freeze/branch/
// latency traffic checked against an instruction-stream reference model.
module tb_if_fetch_stage;
    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        valid_out;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;

    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc_out;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // memory responder state
    bit          busy = 0;
    logic [31:0] maddr = '0;
    int          cnt = 0;
    int          fix_lat = 1;

    // reference model: PC of the next instruction ID should receive
    logic [31:0] exp_pc = '0;
    int          delivered = 0;

    if_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    if_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) wbus ();

    if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .br_taken        (br_taken),
        .br_addr         (br_addr),
        .imem            (bus),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .pc_out          (pc_out)
    );

    if_fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .freeze          (1'b0),
        .br_taken        (1'b0),
        .br_addr         (32'h0),
        .imem            (wbus),
        .valid_out       (w_valid),
        .instruction_out (w_instr),
        .pc_out          (w_pc_out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    // wrap-around instance sees a zero-latency memory
    assign wbus.imem_ack   = wbus.imem_req;
    assign wbus.imem_rdata = mem_word(wbus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: memory response, stream model check, edge, model update.
    task automatic cycle();
        bit brk;
        bit ack;
        if (!rst && busy) begin
            chk("req_held", 64'(bus.imem_req), 64'(1));
            chk("addr_stable", 64'(bus.imem_addr), 64'(maddr));
        end else if (!rst && bus.imem_req === 1'b1) begin
            busy  = 1;
            maddr = bus.imem_addr;
            cnt   = (fix_lat > 0) ? fix_lat - 1 : int'($urandom_range(0, 3));
        end
        ack = busy && (cnt == 0);
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_word(maddr) : 32'hDEAD_BEEF;

        if (!rst && valid_out === 1'b1 && !freeze) begin
            chk("stream_pc", 64'(pc_out), 64'(exp_pc + 32'd4));
            chk("stream_instr", 64'(instruction_out), 64'(mem_word(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        brk = br_taken && !rst;

        @(posedge clk);
        #1;
        if (rst) begin
            busy   = 0;
            exp_pc = 32'h0;
        end else begin
            if (ack) busy = 0;
            else if (busy) cnt--;
            if (brk) exp_pc = {br_addr[31:2], 2'b00};
        end
        bus.imem_ack = 1'b0;
        if (brk) chk("br_flush_valid", 64'(valid_out), 64'(0));
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && valid_out !== 1'b1; i++) cycle();
        chk(tag, 64'(valid_out), 64'(1));
    endtask

    initial begin
        rst            = 1'b1;
        freeze         = 1'b0;
        br_taken       = 1'b0;
        br_addr        = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        // reset state
        cycle();
        cycle();
        chk("rst_valid", 64'(valid_out), 64'(0));
        chk("rst_instr", 64'(instruction_out), 64'(0));
        chk("rst_pc_out", 64'(pc_out), 64'(0));
        chk("rst_req", 64'(bus.imem_req), 64'(0));
        chk("rst_addr", 64'(bus.imem_addr), 64'(0));
        rst = 1'b0;

        // ack every cycle: first instruction two edges after reset release
        fix_lat = 1;
        cycle();
        chk("t1_bubble", 64'(valid_out), 64'(0));
        cycle();
        chk("t1_valid", 64'(valid_out), 64'(1));
        chk("t1_pc_out", 64'(pc_out), 64'(4));
        chk("t1_instr", 64'(instruction_out), 64'(mem_word(32'h0)));
        // reset PC at the top of the address space wraps to 0
        chk("wrap_valid", 64'(w_valid), 64'(1));
        chk("wrap_pc_out", 64'(w_pc_out), 64'(0));
        chk("wrap_instr", 64'(w_instr), 64'(mem_word(32'hFFFF_FFFC)));
        chk("wrap_next_addr", 64'(wbus.imem_addr), 64'(0));
        repeat (8) cycle();

        // latency 3
        fix_lat = 3;
        repeat (12) cycle();

        // freeze with a return landing: skid, hold, release
        fix_lat = 1;
        wait_valid("t3_wait", 20);
        freeze = 1'b1;
        cycle();
        chk("t3_hold_req", 64'(bus.imem_req), 64'(0));
        chk("t3_hold_pc", 64'(pc_out), 64'(exp_pc + 32'd4));
        cycle();
        chk("t3_hold_req2", 64'(bus.imem_req), 64'(0));
        chk("t3_hold_instr", 64'(instruction_out), 64'(mem_word(exp_pc)));
        freeze = 1'b0;
        cycle();
        chk("t3_skid_valid", 64'(valid_out), 64'(1));
        chk("t3_skid_pc", 64'(pc_out), 64'(exp_pc + 32'd4));
        chk("t3_resume_req", 64'(bus.imem_req), 64'(1));
        chk("t3_resume_addr", 64'(bus.imem_addr), 64'(exp_pc + 32'd4));
        repeat (4) cycle();

        // branch mid-request, late ack discarded
        fix_lat = 3;
        wait_valid("t4_wait", 20);
        cycle();
        br_taken = 1'b1;
        br_addr  = 32'h0000_0103;
        cycle();
        br_taken = 1'b0;
        for (int i = 0; i < 10 && busy; i++) cycle();
        chk("t4_drained", 64'(busy), 64'(0));
        chk("t4_refetch_req", 64'(bus.imem_req), 64'(1));
        chk("t4_refetch_addr", 64'(bus.imem_addr), 64'(32'h100));
        wait_valid("t4_wait2", 20);
        chk("t4_pc_out", 64'(pc_out), 64'(32'h104));

        // branch while frozen with the skid full
        fix_lat = 1;
        wait_valid("t5_wait", 20);
        freeze = 1'b1;
        cycle();
        chk("t5_in_hold", 64'(bus.imem_req), 64'(0));
        br_taken = 1'b1;
        br_addr  = 32'h0000_2000;
        cycle();
        br_taken = 1'b0;
        chk("t5_br_req", 64'(bus.imem_req), 64'(1));
        chk("t5_br_addr", 64'(bus.imem_addr), 64'(32'h2000));
        freeze = 1'b0;
        wait_valid("t5_wait2", 20);
        chk("t5_pc_out", 64'(pc_out), 64'(32'h2004));

        // reset while a request is outstanding
        fix_lat = 3;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        chk("t5_rst_req", 64'(bus.imem_req), 64'(0));
        chk("t5_rst_valid", 64'(valid_out), 64'(0));
        rst = 1'b0;
        chk("t5_rst_addr", 64'(bus.imem_addr), 64'(0));
        repeat (6) cycle();

        // randomized traffic
        fix_lat   = 0;
        delivered = 0;
        for (int i = 0; i < 1500; i++) begin
            freeze   = ($urandom_range(0, 3) == 0);
            br_taken = ($urandom_range(0, 29) == 0);
            br_addr  = $urandom();
            rst      = ($urandom_range(0, 399) == 0);
            cycle();
            br_taken = 1'b0;
            rst      = 1'b0;
        end
        freeze = 1'b0;
        repeat (10) cycle();
        chk("liveness", 64'(delivered >= 100), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
